// File: rtl/sprite_dispatcher_pkg.sv
// sprite_dispatcher_pkg
//   Shared definitions for the sprite dispatcher: FSM state encoding,
//   descriptor field offsets and bus widths.
//   Optional build macro: SPRITE_DISPATCH_CLEAR_EN adds the CLEAR state.
package sprite_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_DESC,
      ST_WAIT_DESC,
      ST_RD_ROW1,
      ST_WAIT_ROW1,
      ST_ISSUE,
      ST_DONE
`ifdef SPRITE_DISPATCH_CLEAR_EN
      , ST_CLEAR
`endif
   } state_t;

   // Descriptor layout: [23:16] tex_base, [15:8] z, [7:4] start_x, [3:0] reserved
   localparam int unsigned TEXBASE_MSB = 23;
   localparam int unsigned TEXBASE_LSB = 16;
   localparam int unsigned Z_MSB       = 15;
   localparam int unsigned Z_LSB       = 8;
   localparam int unsigned SX_MSB      = 7;
   localparam int unsigned SX_LSB      = 4;

   localparam int unsigned DESC_W = 24;
   localparam int unsigned ROW_W  = 128;
   localparam int unsigned TEX_W  = 256;

   // Transparent pixel value; interpreted by the processor array, not here.
   localparam logic [7:0] TRANSPARENT = 8'hFF;

endpackage

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher
//   Walks a z-sorted sprite descriptor list, fetches two 16-pixel texture
//   rows per sprite and broadcasts one beat per sprite to the processor array.
//   Optional build macro: SPRITE_DISPATCH_CLEAR_EN (leading clear-colour beat).
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   i_start, i_sprite_count    frame start pulse and list length
//   o_busy, o_done             status / end-of-list pulse
//   o_desc_rd_en/addr, i_desc_data   descriptor memory (1-cycle read latency)
//   o_tex_rd_en/addr,  i_tex_data    texture memory (1-cycle read latency)
//   o_ena, o_texture_data, o_start_x, o_position_z   broadcast beat
module sprite_dispatcher
   import sprite_dispatcher_pkg::*;
#(
   parameter int unsigned TEX_ADDR_W  = 8,
   parameter int unsigned IDX_W       = 6,
   parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_start,
   input  logic [IDX_W-1:0]      i_sprite_count,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_desc_rd_en,
   output logic [IDX_W-1:0]      o_desc_addr,
   input  logic [DESC_W-1:0]     i_desc_data,
   output logic                  o_tex_rd_en,
   output logic [TEX_ADDR_W-1:0] o_tex_addr,
   input  logic [ROW_W-1:0]      i_tex_data,
   output logic                  o_ena,
   output logic [TEX_W-1:0]      o_texture_data,
   output logic [3:0]            o_start_x,
   output logic [7:0]            o_position_z
);

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      idx, idx_inc, count_q;
   logic [TEX_ADDR_W-1:0] tex_base_q;
   logic [7:0]            z_q;
   logic [3:0]            sx_q;
   logic [ROW_W-1:0]      row0_q;

   // Reserved descriptor bits are intentionally ignored.
   logic desc_rsvd_unused;
   assign desc_rsvd_unused = ^i_desc_data[SX_LSB-1:0];

`ifndef SPRITE_DISPATCH_CLEAR_EN
   logic [7:0] clear_color_unused;
   assign clear_color_unused = CLEAR_COLOR;
`endif

   assign idx_inc = idx + IDX_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
`ifdef SPRITE_DISPATCH_CLEAR_EN
               state_nxt = ST_CLEAR;
`else
               state_nxt = (i_sprite_count == '0) ? ST_DONE : ST_RD_DESC;
`endif
            end
         end
`ifdef SPRITE_DISPATCH_CLEAR_EN
         ST_CLEAR:     state_nxt = (count_q == '0) ? ST_DONE : ST_RD_DESC;
`endif
         ST_RD_DESC:   state_nxt = ST_WAIT_DESC;
         ST_WAIT_DESC: state_nxt = ST_RD_ROW1;
         ST_RD_ROW1:   state_nxt = ST_WAIT_ROW1;
         ST_WAIT_ROW1: state_nxt = ST_ISSUE;
         ST_ISSUE:     state_nxt = (idx_inc == count_q) ? ST_DONE : ST_RD_DESC;
         ST_DONE:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Output logic (strobes and addresses are Moore outputs of the state)
   always_comb begin
      o_busy       = (state != ST_IDLE);
      o_done       = 1'b0;
      o_ena        = 1'b0;
      o_desc_rd_en = 1'b0;
      o_desc_addr  = '0;
      o_tex_rd_en  = 1'b0;
      o_tex_addr   = '0;
      case (state)
         ST_RD_DESC: begin
            o_desc_rd_en = 1'b1;
            o_desc_addr  = idx;
         end
         ST_WAIT_DESC: begin
            // Row 0 read is issued straight from the descriptor arriving now.
            o_tex_rd_en = 1'b1;
            o_tex_addr  = TEX_ADDR_W'(i_desc_data[TEXBASE_MSB:TEXBASE_LSB]);
         end
         ST_RD_ROW1: begin
            o_tex_rd_en = 1'b1;
            o_tex_addr  = tex_base_q + TEX_ADDR_W'(1);
         end
`ifdef SPRITE_DISPATCH_CLEAR_EN
         ST_CLEAR: o_ena = 1'b1;
`endif
         ST_ISSUE: o_ena  = 1'b1;
         ST_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: descriptor latch, row assembly and registered broadcast beat
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx            <= '0;
         count_q        <= '0;
         tex_base_q     <= '0;
         z_q            <= '0;
         sx_q           <= '0;
         row0_q         <= '0;
         o_texture_data <= '0;
         o_start_x      <= '0;
         o_position_z   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  count_q <= i_sprite_count;
                  idx     <= '0;
`ifdef SPRITE_DISPATCH_CLEAR_EN
                  o_texture_data <= {(TEX_W/8){CLEAR_COLOR}};
                  o_start_x      <= '0;
                  o_position_z   <= '0;
`endif
               end
            end
            ST_WAIT_DESC: begin
               tex_base_q <= TEX_ADDR_W'(i_desc_data[TEXBASE_MSB:TEXBASE_LSB]);
               z_q        <= i_desc_data[Z_MSB:Z_LSB];
               sx_q       <= i_desc_data[SX_MSB:SX_LSB];
            end
            ST_RD_ROW1: row0_q <= i_tex_data;
            ST_WAIT_ROW1: begin
               // Row 1 goes straight into the beat so it is valid during ISSUE.
               o_texture_data <= {i_tex_data, row0_q};
               o_start_x      <= sx_q;
               o_position_z   <= z_q;
            end
            ST_ISSUE: idx <= idx_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sprite_dispatcher.md
Name: sprite_dispatcher

Overview:
- Producer side of the stream-processor broadcast bus: walks a sprite descriptor list, fetches each sprite's two 16-pixel texture rows from texture memory, and broadcasts one {texture_data, start_x, position_z, ena} beat per sprite to the 2x16 stream-processor array.
- Sits between the frame controller (start/done) and the processor array.
- Sprites are issued strictly in list order; the list is z-sorted upstream (ascending z).

Parameters:
- TEX_ADDR_W, 8, texture memory row-address width.
- IDX_W, 6, sprite index / count width (max 2^IDX_W - 1 sprites).
- CLEAR_COLOR, 8'h00, fill colour for the optional clear pass.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse; sampled only in IDLE.
- i_sprite_count  in  IDX_W  number of descriptors; latched on accepted start.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at end of list.
- o_desc_rd_en  out  1  descriptor memory read strobe.
- o_desc_addr  out  IDX_W  descriptor index.
- i_desc_data  in  24  valid cycle after rd_en: [23:16] tex_base, [15:8] z, [7:4] start_x, [3:0] reserved (ignored).
- o_tex_rd_en  out  1  texture memory read strobe.
- o_tex_addr  out  TEX_ADDR_W  texture row address.
- i_tex_data  in  128  valid cycle after rd_en; pixel p in bits [8p+7:8p].
- o_ena  out  1  one-cycle broadcast strobe to array.
- o_texture_data  out  256  row0 in [127:0], row1 in [255:128] (index = y*16 + x).
- o_start_x  out  4  sprite column origin.
- o_position_z  out  8  sprite depth.

Behaviour:
- Reset: state IDLE; o_busy, o_done, o_ena, rd strobes = 0; addresses, o_texture_data, o_start_x, o_position_z = 0; index = 0. Reset mid-operation aborts immediately; no o_done.
- States: IDLE, RD_DESC, WAIT_DESC, RD_ROW1, WAIT_ROW1, ISSUE, DONE.
- IDLE: on i_start, latch count, idx = 0; count==0 -> DONE, else RD_DESC.
- RD_DESC: o_desc_rd_en = 1, o_desc_addr = idx.
- WAIT_DESC: latch desc; o_tex_rd_en = 1, o_tex_addr = tex_base.
- RD_ROW1: latch i_tex_data into row0; o_tex_rd_en = 1, o_tex_addr = tex_base + 1 (mod 2^TEX_ADDR_W, wraps 255 -> 0).
- WAIT_ROW1: latch row1.
- ISSUE: o_ena = 1 with o_texture_data/o_start_x/o_position_z valid the same cycle; idx++; idx+1 == count -> DONE, else RD_DESC.
- DONE: o_done = 1 for one cycle -> IDLE.
- Broadcast outputs are registered and hold their last value after o_ena drops.
- Latency: start accepted at edge N gives RD_DESC in cycle N+1; sprite k o_ena in cycle N+5+5k; o_done in cycle after last ISSUE.
- i_start while busy: ignored, not queued. i_sprite_count changes after start: no effect.
- Data pass-through is unmodified; transparency (8'hFF) and depth tests are the array's job.

Optional Feature:
- SPRITE_DISPATCH_CLEAR_EN
- Defined: an accepted start first enters CLEAR, a single ISSUE-type beat with o_ena = 1, o_start_x = 0, o_position_z = 0, o_texture_data = {32{CLEAR_COLOR}}, in cycle N+1. The sprite sequence then starts one cycle later (sprite k ena at N+6+5k). count==0 gives CLEAR then DONE.
- Undefined: no CLEAR state; timing as above.

Decomposition:
- Shared package: state enum; descriptor field offsets (TEXBASE_MSB/LSB, Z_MSB/LSB, SX_MSB/LSB); DESC_W = 24; ROW_W = 128; TEX_W = 256; TRANSPARENT = 8'hFF.
- Single module; no natural sub-module (row assembly is two register loads).

Test Plan:
- 1 sprite, desc {base=8'h10, z=8'h05, sx=4'h3}, tex[0x10] = 0x00..0F bytes, tex[0x11] = 0x10..1F -> one o_ena at N+5, o_texture_data bytes 0..31 = 0x00..0x1F, start_x = 3, z = 5, o_done at N+6.
- 3 sprites -> o_ena at N+5, N+10, N+15, fields match each descriptor in order, o_desc_addr 0,1,2, o_done at N+16, o_busy low at N+17.
- count = 0 -> no o_ena, no memory reads, o_done at N+1.
- base = 8'hFF -> tex reads at 0xFF then 0x00.
- Second i_start pulsed during sprite 0 -> ignored, exactly count beats issued. reset_n low in WAIT_ROW1 -> next cycle IDLE, all outputs 0, no o_ena/o_done.
- With SPRITE_DISPATCH_CLEAR_EN, CLEAR_COLOR = 8'h20, 1 sprite -> o_ena at N+1 with z = 0, sx = 0, data all 0x20; sprite beat at N+6.
